// File: rtl/memory_loader_pkg.sv
// Shared sizing, FSM encoding and fixed-point constants for the memory loader.
package memory_loader_pkg;

    localparam int WIDTH = 5;   // signed element, 3 fractional bits
    localparam int N     = 4;   // vector length, weights are N x N

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_X = 2'd1,
        LOAD_W = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] ONE     = 5'b01000;  // +1.0
    localparam logic [WIDTH-1:0] NEG_EPS = 5'b11110;  // -0.25

    // Counter must index N*N weights; keep at least one bit for N = 1.
    function automatic int cnt_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/memory_loader_if.sv
// Start / data handshake between a producer and the loader.
interface memory_loader_if #(
    parameter int WIDTH = memory_loader_pkg::WIDTH
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (output start, data_in, data_valid, input data_ready);
    modport slave  (input start, data_in, data_valid, output data_ready);
endinterface

// File: rtl/memory_loader_ctrl.sv
// Load sequencer: walks X then W element by element, one per accepted transfer.
module loader_ctrl
    import memory_loader_pkg::*;
#(
    parameter int N  = memory_loader_pkg::N,
    parameter int CW = cnt_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          loaded_o,
    output logic          wr_x_o,
    output logic          wr_w_o,
    output logic [CW-1:0] cnt_o
);

    localparam logic [CW-1:0] X_LAST = CW'(N - 1);
    localparam logic [CW-1:0] W_LAST = CW'(N * N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy, xfer;

    // State and element counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: start only honoured when not busy; counter moves only on a transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = (state_q == LOAD_X) || (state_q == LOAD_W);
        xfer    = busy && valid_i;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = LOAD_X;
                    cnt_d   = '0;
                end
            end
            LOAD_X: begin
                if (xfer) begin
                    if (cnt_q == X_LAST) begin
                        state_d = LOAD_W;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (xfer) begin
                    if (cnt_q == W_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o   = busy;
    assign ready_o  = busy;
    assign loaded_o = (state_q == DONE);
    assign wr_x_o   = xfer && (state_q == LOAD_X);
    assign wr_w_o   = xfer && (state_q == LOAD_W);
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/memory_loader.sv
// Streams an input vector X and weight matrix W into register banks.
module memory_loader
    import memory_loader_pkg::*;
#(
    parameter int WIDTH = memory_loader_pkg::WIDTH,
    parameter int N     = memory_loader_pkg::N
) (
    input  logic                     clk,
    input  logic                     rst,
    memory_loader_if.slave           bus,
    output logic [N*WIDTH-1:0]       X_out,
    output logic [N*N*WIDTH-1:0]     W_out,
    output logic                     loaded,
    output logic                     busy
);

    localparam int CW = cnt_w(N);

    logic [N-1:0][WIDTH-1:0]   x_q;
    logic [N*N-1:0][WIDTH-1:0] w_q;
    logic                      wr_x, wr_w;
    logic [CW-1:0]             cnt;

    loader_ctrl #(.N(N), .CW(CW)) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start_i  (bus.start),
        .valid_i  (bus.data_valid),
        .ready_o  (bus.data_ready),
        .busy_o   (busy),
        .loaded_o (loaded),
        .wr_x_o   (wr_x),
        .wr_w_o   (wr_w),
        .cnt_o    (cnt)
    );

    // Storage banks: only the element addressed by the counter is written on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            w_q <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (wr_x && cnt == CW'(i)) x_q[i] <= bus.data_in;
            for (int j = 0; j < N * N; j++)
                if (wr_w && cnt == CW'(j)) w_q[j] <= bus.data_in;
        end
    end

    assign X_out = x_q;
    assign W_out = w_q;

endmodule

// File: doc/memory_loader.md
MEMORY_LOADER -- requirements
Module: memory_loader

Interface
REQ-001 Parameter WIDTH, default 5, SHALL set the bit width of each element (signed, 3 fractional bits).
REQ-002 Parameter N, default 4, SHALL set the vector length; the weight matrix SHALL be N x N.
REQ-003 clk  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a single-cycle request to begin a new load sequence.
REQ-006 data_in  input  WIDTH  SHALL carry one element per accepted transfer.
REQ-007 data_valid  input  1  SHALL mark data_in as valid.
REQ-008 data_ready  output  1  SHALL mark that the loader accepts data_in this cycle.
REQ-009 X_out  output  N*WIDTH  SHALL be the input vector, with element i at bits [i*WIDTH +: WIDTH].
REQ-010 W_out  output  N*N*WIDTH  SHALL be the weight matrix, with element r*N+c at bits [(r*N+c)*WIDTH +: WIDTH].
REQ-011 loaded  output  1  SHALL be high while X_out and W_out hold a complete, consistent set.
REQ-012 busy  output  1  SHALL be high in states LOAD_X and LOAD_W.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, LOAD_X, LOAD_W and DONE.
REQ-014 In IDLE or DONE, start SHALL cause a transition to LOAD_X, clear the element counter to 0 and deassert loaded on the next cycle.
REQ-015 A transfer SHALL occur only on a cycle where data_valid and data_ready are both high; no other cycle changes the counter or the storage.
REQ-016 data_ready SHALL equal busy (combinational from state) and SHALL NOT depend on data_valid.
REQ-017 In LOAD_X, transfer k (k = 0..N-1) SHALL write data_in into X element k; after transfer N-1 the FSM SHALL enter LOAD_W and the counter SHALL return to 0.
REQ-018 In LOAD_W, transfer k (k = 0..N*N-1) SHALL write data_in into W element k (row-major); after transfer N*N-1 the FSM SHALL enter DONE.
REQ-019 Written data SHALL be visible on X_out/W_out on the cycle after the transfer (latency 1).
REQ-020 loaded SHALL assert on the cycle the FSM enters DONE and stay high until the next start or reset.
REQ-021 Total accepted transfers per sequence SHALL be N + N*N (20 at defaults); transfers with data_valid high while idle or done SHALL be ignored.
REQ-022 start asserted while busy SHALL be ignored; the sequence in progress SHALL continue unaffected.
REQ-023 Gaps (data_valid low) SHALL stall the sequence indefinitely without loss of state.
REQ-024 The counter SHALL be ceil(log2(N*N)) bits wide and SHALL never exceed N*N-1.
REQ-025 Elements not yet rewritten during a new sequence SHALL retain their previous values; loaded low marks them invalid.

Reset
REQ-026 rst SHALL force IDLE, counter 0, loaded 0, busy 0, data_ready 0 and all X_out/W_out elements 0 on the next edge.
REQ-027 rst asserted mid-sequence SHALL abandon the sequence; the next load SHALL require a new start.
REQ-028 rst SHALL take priority over start and data_valid in the same cycle.

Structure
REQ-029 A shared package SHALL hold WIDTH, N, the FSM state encoding, and the fixed-point constants ONE = 5'b01000 and NEG_EPS = 5'b11110.
REQ-030 A single sub-module, loader_ctrl (FSM + counter), SHALL be used; the storage banks SHALL be in memory_loader.

Verification
REQ-031 Reset, then start, then 20 back-to-back transfers of the values 0..19 (5-bit) -> X_out elements = 0..3, W_out elements = 4..19, loaded high on the cycle after transfer 19.
REQ-032 Load the diagonal ONE / off-diagonal NEG_EPS weight pattern with X = {3,5,7,2} -> W_out elements 0, 5, 10, 15 = 01000, all other W_out elements = 11110, X_out matches.
REQ-033 Toggle data_valid randomly (50%) during a load -> the same final contents as back-to-back, and busy high throughout.
REQ-034 Assert rst after 10 transfers -> all outputs 0 next cycle; then start with 20 transfers -> correct contents and loaded high.
REQ-035 Assert start at transfer 7 -> ignored, and the load completes after 20 transfers; data_valid with start low in IDLE -> no storage change.
REQ-036 Assert start in DONE -> loaded low next cycle, and previous contents held until overwritten.
